// File: rtl/match_tracker.sv
// Best-of-three match controller: records round winners, paces the inter-round
// break and the game-over hold from synchronised VGA frame ticks.
module match_tracker #(
    parameter int BREAK_FRAMES = 60,
    parameter int HOLD_FRAMES  = 120,
    parameter int CNT_W        = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       start,
    input  logic       round_done,
    input  logic [1:0] round_winner,
    output logic       round_active,
    output logic [1:0] round_num,
    output logic [1:0] winner,
    output logic [1:0] winner2,
    output logic [1:0] winner3,
    output logic       is_GameOver,
    output logic [1:0] OVERALL_winner
);

    typedef enum logic [1:0] {IDLE, PLAY, BREAK, OVER} state_t;

    localparam logic [CNT_W-1:0] BRK_LOAD = CNT_W'(BREAK_FRAMES);
    localparam logic [CNT_W-1:0] HLD_LOAD = CNT_W'(HOLD_FRAMES);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fq1_q, fq2_q, fq3_q;
    logic [1:0]       rnum_q, w1_q, w2_q, w3_q, ovr_q;

    logic       tick;
    logic       valid_code;
    logic [1:0] w1_d, w2_d, w3_d;
    logic [1:0] wins;
    logic       match_won;

    assign tick       = fq2_q & ~fq3_q;
    assign valid_code = (round_winner == 2'd1) || (round_winner == 2'd2);

    // Slot contents as they will be after this round's write, so the
    // match-decided check lands in the same edge as the write itself.
    assign w1_d = (rnum_q == 2'd1) ? round_winner : w1_q;
    assign w2_d = (rnum_q == 2'd2) ? round_winner : w2_q;
    assign w3_d = (rnum_q == 2'd3) ? round_winner : w3_q;
    assign wins = 2'(w1_d == round_winner) + 2'(w2_d == round_winner)
                + 2'(w3_d == round_winner);
    assign match_won = (wins >= 2'd2);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fq1_q   <= 1'b0;
            fq2_q   <= 1'b0;
            fq3_q   <= 1'b0;
            rnum_q  <= 2'd0;
            w1_q    <= 2'd0;
            w2_q    <= 2'd0;
            w3_q    <= 2'd0;
            ovr_q   <= 2'd0;
        end else begin
            fq1_q <= frame_clk;
            fq2_q <= fq1_q;
            fq3_q <= fq2_q;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= PLAY;
                        rnum_q  <= 2'd1;
                        w1_q    <= 2'd0;
                        w2_q    <= 2'd0;
                        w3_q    <= 2'd0;
                        ovr_q   <= 2'd0;
                    end
                end
                PLAY: begin
                    if (round_done && valid_code) begin
                        w1_q <= w1_d;
                        w2_q <= w2_d;
                        w3_q <= w3_d;
                        if (match_won) begin
                            state_q <= OVER;
                            ovr_q   <= round_winner;
                            cnt_q   <= HLD_LOAD;
                        end else begin
                            state_q <= BREAK;
                            cnt_q   <= BRK_LOAD;
                        end
                    end
                end
                BREAK: begin
                    if (cnt_q == '0) begin
                        state_q <= PLAY;
                        if (rnum_q != 2'd3) rnum_q <= rnum_q + 2'd1;
                    end else if (tick) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                OVER: begin
                    // A start during the hold is dropped, not remembered.
                    if (start && cnt_q == '0) begin
                        state_q <= PLAY;
                        rnum_q  <= 2'd1;
                        w1_q    <= 2'd0;
                        w2_q    <= 2'd0;
                        w3_q    <= 2'd0;
                        ovr_q   <= 2'd0;
                    end else if (tick && cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign round_active   = (state_q == PLAY);
    assign is_GameOver    = (state_q == OVER);
    assign round_num      = rnum_q;
    assign winner         = w1_q;
    assign winner2        = w2_q;
    assign winner3        = w3_q;
    assign OVERALL_winner = ovr_q;

endmodule

// File: tb/tb_match_tracker.sv
// Bench for match_tracker: directed match scenarios then random traffic, all
// checked every cycle against a phase/results model of the match rules.
module tb_match_tracker;

    localparam int BRK = 2;
    localparam int HLD = 3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic       start = 1'b0;
    logic       round_done = 1'b0;
    logic [1:0] round_winner = 2'd0;
    logic       round_active, is_GameOver;
    logic [1:0] round_num, winner, winner2, winner3, OVERALL_winner;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    match_tracker #(.BREAK_FRAMES(BRK), .HOLD_FRAMES(HLD), .CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
        .round_done(round_done), .round_winner(round_winner),
        .round_active(round_active), .round_num(round_num), .winner(winner),
        .winner2(winner2), .winner3(winner3), .is_GameOver(is_GameOver),
        .OVERALL_winner(OVERALL_winner)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle 1=playing 2=between rounds 3=match over.
    int m_phase = 0;
    int m_round = 0;
    int m_wait = 0;
    int m_overall = 0;
    int m_res [1:3] = '{0, 0, 0};
    bit fh [0:2] = '{0, 0, 0};   // frame_clk samples from the last three edges

    always @(posedge Clk) begin
        bit tk;
        bit samp;
        int wins;
        // A tick is seen two edges after the rising sample of frame_clk.
        tk = fh[1] && !fh[2];
        samp = Reset ? frame_clk : 1'b0;
        fh[2] = fh[1]; fh[1] = fh[0]; fh[0] = samp;
        if (!Reset) begin
            m_phase = 0; m_round = 0; m_wait = 0; m_overall = 0;
            for (int i = 1; i <= 3; i++) m_res[i] = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_round = 1; m_overall = 0;
                    for (int i = 1; i <= 3; i++) m_res[i] = 0;
                end
                1: if (round_done && (round_winner == 1 || round_winner == 2)) begin
                    m_res[m_round] = round_winner;
                    wins = 0;
                    for (int i = 1; i <= 3; i++) if (m_res[i] == round_winner) wins++;
                    if (wins >= 2) begin
                        m_phase = 3; m_overall = round_winner; m_wait = HLD;
                    end else begin
                        m_phase = 2; m_wait = BRK;
                    end
                end
                2: if (m_wait == 0) begin
                    m_phase = 1; m_round = m_round + 1;
                end else if (tk) m_wait--;
                default: if (start && m_wait == 0) begin
                    m_phase = 1; m_round = 1; m_overall = 0;
                    for (int i = 1; i <= 3; i++) m_res[i] = 0;
                end else if (tk && m_wait > 0) m_wait--;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("round_active", round_active, m_phase == 1);
            check("is_GameOver", is_GameOver, m_phase == 3);
            check("round_num", round_num, m_round);
            check("winner", winner, m_res[1]);
            check("winner2", winner2, m_res[2]);
            check("winner3", winner3, m_res[3]);
            check("OVERALL_winner", OVERALL_winner, m_overall);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1; cyc(4);
        frame_clk = 1'b0; cyc(4);
    endtask

    task automatic done_pulse(input logic [1:0] w);
        round_done = 1'b1; round_winner = w; cyc();
        round_done = 1'b0; round_winner = 2'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc();
        start = 1'b0;
    endtask

    initial begin
        int half;
        cyc(2);
        chk_en = 1'b1;
        Reset = 1'b1;
        cyc();
        check("rst_active", round_active, 0);
        check("rst_num", round_num, 0);
        check("rst_over", is_GameOver, 0);
        check("rst_overall", OVERALL_winner, 0);
        pulse_start();
        check("start_active", round_active, 1);
        check("start_num", round_num, 1);

        // Player 1 takes rounds 1 and 2.
        done_pulse(2'd1);
        check("r1_break", round_active, 0);
        frame_tick(); frame_tick();
        check("r2_active", round_active, 1);
        check("r2_num", round_num, 2);
        done_pulse(2'd1);
        check("sweep_w1", winner, 1);
        check("sweep_w2", winner2, 1);
        check("sweep_w3", winner3, 0);
        check("sweep_over", is_GameOver, 1);
        check("sweep_overall", OVERALL_winner, 1);
        check("sweep_active", round_active, 0);
        check("model_sweep_overall", m_overall, 1);

        // Start during the hold is dropped; after the last tick it restarts.
        frame_tick(); frame_tick();
        pulse_start();
        check("hold_over", is_GameOver, 1);
        frame_tick();
        check("hold_still_over", is_GameOver, 1);
        pulse_start();
        check("restart_active", round_active, 1);
        check("restart_num", round_num, 1);
        check("restart_w1", winner, 0);
        check("restart_over", is_GameOver, 0);

        // Ignored inputs, then a 1-2-2 split.
        done_pulse(2'd3);
        check("bad_code_active", round_active, 1);
        check("bad_code_w1", winner, 0);
        start = 1'b1; done_pulse(2'd1); start = 1'b0;
        check("start_done_w1", winner, 1);
        check("start_done_break", round_active, 0);
        done_pulse(2'd2);
        pulse_start();
        check("break_ignore_w1", winner, 1);
        check("break_ignore_w2", winner2, 0);
        frame_tick();
        check("break_one_tick", round_active, 0);
        frame_tick();
        done_pulse(2'd2);
        frame_tick(); frame_tick();
        check("split_r3_num", round_num, 3);
        done_pulse(2'd2);
        check("split_w1", winner, 1);
        check("split_w2", winner2, 2);
        check("split_w3", winner3, 2);
        check("split_overall", OVERALL_winner, 2);
        check("split_num", round_num, 3);
        check("model_split_w3", m_res[3], 2);

        // Reset in the break after round 2 throws the match away.
        repeat (3) frame_tick();
        pulse_start();
        done_pulse(2'd1);
        frame_tick(); frame_tick();
        done_pulse(2'd2);
        Reset = 1'b0; cyc();
        check("midrst_num", round_num, 0);
        check("midrst_w1", winner, 0);
        check("midrst_w2", winner2, 0);
        Reset = 1'b1;
        repeat (3) frame_tick();
        check("idle_stays", round_active, 0);
        check("idle_num", round_num, 0);

        // Random traffic.
        half = 3;
        for (int i = 0; i < 6000; i++) begin
            start        = ($urandom_range(0, 11) == 0);
            round_done   = ($urandom_range(0, 5) == 0);
            round_winner = 2'($urandom_range(0, 3));
            Reset        = ($urandom_range(0, 899) != 0);
            if (--half == 0) begin
                frame_clk = ~frame_clk;
                half = $urandom_range(2, 6);
            end
            cyc();
        end
        start = 1'b0; round_done = 1'b0; Reset = 1'b1;
        cyc(2);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
